// File: rtl/music_pkg.sv
// music_sample_player shared types and defaults.
// State encoding plus the song-end marker and the default pacing.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOAD,
    PLAY
  } state_t;

  localparam logic [7:0] C_END_MARK   = 8'hFF;
  localparam int         C_SAMPLE_DIV = 6250;

endpackage

// File: rtl/music_sample_player_if.sv
// Bundle between the ROM read path / play control and the player.
// master drives control and ROM data, slave produces audio and steps.
interface music_sample_player_if;

  logic       play;
  logic       flush;
  logic [7:0] data;
  logic       advance;
  logic       end_of_song;
  logic [7:0] sample;
  logic       pwm_out;

  modport master (
    output play, flush, data,
    input  advance, end_of_song, sample, pwm_out
  );

  modport slave (
    input  play, flush, data,
    output advance, end_of_song, sample, pwm_out
  );

endinterface

// File: rtl/music_sample_player_pwm_dac8.sv
// 8-bit PWM DAC: free counter compared against the held level.
// Output is gated by en so a paused player stays silent.
module pwm_dac8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] level,
  output logic       pwm_out
);

  logic [7:0] r_pwm_cnt;

  // counter advances only while playing, wraps 255 -> 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  r_pwm_cnt <= '0;
    else if (en) r_pwm_cnt <= r_pwm_cnt + 8'd1;
  end

  assign pwm_out = en & (r_pwm_cnt < level);

endmodule

// File: rtl/music_sample_player.sv
// Paced ROM sample fetch: settle, load, play one period, advance.
// FSM and the shared settle/dwell counter live here.
module music_sample_player
  import music_pkg::*;
#(
  parameter int         SAMPLE_DIV = C_SAMPLE_DIV,
  parameter int         SETTLE_CYC = 1,
  parameter logic [7:0] END_MARK   = C_END_MARK
) (
  input  logic                  clk,
  input  logic                  reset,
  music_sample_player_if.slave  bus
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] SET_LD  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] PLAY_LD = CW'(SAMPLE_DIV - SETTLE_CYC - 2);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_sample;

  logic w_live;
  logic w_step;
  logic w_cnt_zero;
  logic w_is_mark;
  logic w_pwm_en;

  assign w_live     = (r_state != IDLE);
  assign w_step     = w_live & bus.play & ~bus.flush;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_is_mark  = (bus.data == END_MARK);
  assign w_pwm_en   = w_live & bus.play;

  // sequencer: flush beats everything, pause freezes state and count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sample <= '0;
    end else if (!w_live) begin
      if (bus.play) begin
        r_state <= SETTLE;
        r_cnt   <= SET_LD;
      end
    end else if (bus.flush) begin
      r_state <= SETTLE;
      r_cnt   <= SET_LD;
    end else if (bus.play) begin
      unique case (r_state)
        SETTLE: begin
          if (w_cnt_zero) r_state <= LOAD;
          else            r_cnt   <= r_cnt - 1'b1;
        end
        LOAD: begin
          if (w_is_mark) begin
            r_state <= SETTLE;
            r_cnt   <= SET_LD;
          end else begin
            r_sample <= bus.data;
            r_state  <= PLAY;
            r_cnt    <= PLAY_LD;
          end
        end
        PLAY: begin
          if (w_cnt_zero) begin
            r_state <= SETTLE;
            r_cnt   <= SET_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.advance =
    w_step & (r_state == PLAY) & w_cnt_zero;
  assign bus.end_of_song =
    w_step & (r_state == LOAD) & w_is_mark;
  assign bus.sample = r_sample;

  pwm_dac8 u_pwm (
    .clk     (clk),
    .reset   (reset),
    .en      (w_pwm_en),
    .level   (r_sample),
    .pwm_out (bus.pwm_out)
  );

endmodule

// File: tb/tb_music_sample_player.sv
// Directed bench for music_sample_player, SAMPLE_DIV=8 SETTLE_CYC=1.
// Cycle 0 is the first cycle with play=1 after reset release.
module tb_music_sample_player;

  localparam int SD = 8;
  localparam int SC = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  music_sample_player_if bus ();
  music_sample_player_if bus2 ();

  music_sample_player #(
    .SAMPLE_DIV (SD),
    .SETTLE_CYC (SC),
    .END_MARK   (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // second player with a different marker so 8'hFF can be played
  music_sample_player #(
    .SAMPLE_DIV (SD),
    .SETTLE_CYC (SC),
    .END_MARK   (8'h00)
  ) dut_ff (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.play  = bus.play;
  assign bus2.flush = 1'b0;
  assign bus2.data  = 8'hFF;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] d);
    reset      = 1'b0;
    bus.play   = 1'b0;
    bus.flush  = 1'b0;
    bus.data   = d;
    nxt();
    reset    = 1'b1;
    bus.play = 1'b1;
  endtask

  int n_hi;
  int n_hi2;

  initial begin
    reset     = 1'b0;
    bus.play  = 1'b0;
    bus.flush = 1'b0;
    bus.data  = 8'h5A;

    // reset: outputs stay 0 whatever play/flush do
    for (int i = 0; i < 6; i++) begin
      bus.play  = i[0];
      bus.flush = i[1];
      @(negedge clk);
      check("rst_adv", 32'(bus.advance), 0);
      check("rst_eos", 32'(bus.end_of_song), 0);
      check("rst_smp", 32'(bus.sample), 0);
      check("rst_pwm", 32'(bus.pwm_out), 0);
      nxt();
    end

    // start-up: LOAD c2, sample c3, advance c8, next LOAD c10
    start(8'h40);
    for (int c = 0; c <= 11; c++) begin
      if (c == 9) bus.data = 8'h41;
      @(negedge clk);
      check($sformatf("su_adv%0d", c),
            32'(bus.advance), 32'(c == 8));
      check($sformatf("su_eos%0d", c),
            32'(bus.end_of_song), 0);
      check($sformatf("su_smp%0d", c), 32'(bus.sample),
            (c < 3) ? 0 : (c <= 10) ? 32'h40 : 32'h41);
      nxt();
    end

    // duty 64/256 over a full counter period of constant 8'h40
    start(8'h40);
    n_hi = 0;
    for (int c = 0; c <= 258; c++) begin
      @(negedge clk);
      if (c >= 3 && bus.pwm_out) n_hi++;
      nxt();
    end
    check("duty_40", 32'(n_hi), 64);

    // pause c5..c9: silent, no advance, advance slips to c13
    start(8'h40);
    for (int c = 0; c <= 14; c++) begin
      if (c == 5)  bus.play = 1'b0;
      if (c == 10) bus.play = 1'b1;
      @(negedge clk);
      check($sformatf("pa_adv%0d", c),
            32'(bus.advance), 32'(c == 13));
      if (c >= 5 && c <= 9) begin
        check($sformatf("pa_pwm%0d", c), 32'(bus.pwm_out), 0);
        check($sformatf("pa_smp%0d", c), 32'(bus.sample), 32'h40);
      end
      nxt();
    end

    // flush on the advance cycle: no advance, reload at c10
    start(8'h40);
    for (int c = 0; c <= 17; c++) begin
      if (c == 8) begin
        bus.flush = 1'b1;
        bus.data  = 8'h55;
      end
      if (c == 9) bus.flush = 1'b0;
      @(negedge clk);
      check($sformatf("fl_adv%0d", c),
            32'(bus.advance), 32'(c == 16));
      check($sformatf("fl_smp%0d", c), 32'(bus.sample),
            (c < 3) ? 0 : (c <= 10) ? 32'h40 : 32'h55);
      nxt();
    end

    // end marker at LOAD c10: pulse, hold sample, LOAD again c12
    start(8'h30);
    for (int c = 0; c <= 13; c++) begin
      if (c == 9)  bus.data = 8'hFF;
      if (c == 11) bus.data = 8'h80;
      @(negedge clk);
      check($sformatf("em_eos%0d", c),
            32'(bus.end_of_song), 32'(c == 10));
      check($sformatf("em_adv%0d", c),
            32'(bus.advance), 32'(c == 8));
      check($sformatf("em_smp%0d", c), 32'(bus.sample),
            (c < 3) ? 0 : (c <= 12) ? 32'h30 : 32'h80);
      nxt();
    end

    // duty extremes: 8'h00 on dut, 8'hFF on dut_ff
    start(8'h00);
    n_hi  = 0;
    n_hi2 = 0;
    for (int c = 0; c <= 258; c++) begin
      @(negedge clk);
      if (c >= 3 && bus.pwm_out)  n_hi++;
      if (c >= 3 && bus2.pwm_out) n_hi2++;
      nxt();
    end
    check("duty_00", 32'(n_hi), 0);
    check("duty_ff", 32'(n_hi2), 255);
    check("ff_smp", 32'(bus2.sample), 32'hFF);

    // asynchronous reset mid-cycle clears without a clock edge
    reset = 1'b0;
    #1;
    check("arst_smp", 32'(bus2.sample), 0);
    check("arst_pwm", 32'(bus2.pwm_out), 0);
    check("arst_eos", 32'(bus2.end_of_song), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
